// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Holds the NOP encoding loaded on an if_id flush, the controller state
// encodings and the hard-wired zero-register index.
package pipe_ctrl_pkg;

  localparam logic [31:0] NopInst = 32'h0000_0013;
  localparam logic [4:0]  ZeroReg = 5'd0;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFlush = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register scoreboard of in-flight writebacks.
// Each architectural register x1..x31 has a down-counter; a nonzero count
// means the value is not yet readable from the register file. x0 has no
// counter and always reads as not busy.
//
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   advance_i     pipe is not held: nonzero counters decrement
//   set_i         an instruction writing rd_addr_i issues this cycle
//   rd_addr_i     destination of the issuing instruction
//   rs1_addr_i    ID source 1 index to look up
//   rs2_addr_i    ID source 2 index to look up
//   rs1_busy_o    source 1 still has a writeback in flight
//   rs2_busy_o    source 2 still has a writeback in flight
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned SetLat = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance_i,
  input  logic       set_i,
  input  logic [4:0] rd_addr_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o
);

  localparam int unsigned CntW = $clog2(WB_LAT + 1);

  logic [CntW-1:0] cnt_q [1:31];
  logic [CntW-1:0] cnt_d [1:31];
  logic [31:0]     busy;

  always_comb begin
    busy = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (advance_i && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
      // A new writer restarts the count even if an older one is still pending.
      if (set_i && (rd_addr_i == 5'(i))) begin
        cnt_d[i] = CntW'(SetLat);
      end
      busy[i] = |cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // busy[0] is tied low, so x0 never stalls.
  assign rs1_busy_o = busy[rs1_addr_i] & (rs1_addr_i != ZeroReg);
  assign rs2_busy_o = busy[rs2_addr_i] & (rs2_addr_i != ZeroReg);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 3-stage core (IF, ID, EX).
// Stalls ID on operands with writebacks in flight, redirects the pc and
// flushes younger stages on an EX-resolved jump, and freezes the whole pipe
// on a bus hold. Output priority: hold > jump > hazard.
//
// Optional feature macro: PIPE_CTRL_FWD_EN
//   defined   - EX/MEM forwarding exists; only loads mark their rd busy, for
//               one cycle, giving a single bubble on load-use.
//   undefined - every writer marks rd busy for WB_LAT cycles; id_is_load_i
//               is ignored.
//
// Ports:
//   clk, rst                        core clock, asynchronous active-high reset
//   id_valid_i                      ID holds a valid instruction
//   id_rs1/rs2_addr_i, _used_i      ID source indices and read enables
//   id_rd_addr_i, id_reg_wen_i      ID destination and write enable
//   id_is_load_i                    ID instruction is a load
//   ex_jump_i, ex_jump_addr_i       EX taken jump and its target
//   hold_req_i                      full-pipe freeze request
//   pc_hold_o, pc_jump_o            pc keep / pc load redirect target
//   pc_jump_addr_o                  redirect target
//   if_id_hold_o, if_id_flush_o     if_id keep / load NOP
//   id_ex_hold_o, id_ex_flush_o     id_ex keep / load bubble
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WB_LAT    = 3,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_reg_wen_i,
  input  logic        id_is_load_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        hold_req_i,
  output logic        pc_hold_o,
  output logic        pc_jump_o,
  output logic [31:0] pc_jump_addr_o,
  output logic        if_id_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_hold_o,
  output logic        id_ex_flush_o
);

`ifdef PIPE_CTRL_FWD_EN
  localparam int unsigned SetLat = 1;
  logic writes_busy;
  assign writes_busy = id_is_load_i & id_reg_wen_i;
`else
  localparam int unsigned SetLat = WB_LAT;
  logic writes_busy;
  logic unused_is_load;
  assign writes_busy    = id_reg_wen_i;
  assign unused_is_load = id_is_load_i;
`endif

  ctrl_state_e state_q, state_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic        rs1_busy, rs2_busy;
  logic        raw_haz;
  logic        issue;
  logic        advance;

  pipe_scoreboard #(
    .WB_LAT (WB_LAT),
    .SetLat (SetLat)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .advance_i  (advance),
    .set_i      (issue & writes_busy),
    .rd_addr_i  (id_rd_addr_i),
    .rs1_addr_i (id_rs1_addr_i),
    .rs2_addr_i (id_rs2_addr_i),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

  assign raw_haz = id_valid_i & ((id_rs1_used_i & rs1_busy) | (id_rs2_used_i & rs2_busy));

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    issue          = 1'b0;
    advance        = 1'b0;
    pc_hold_o      = 1'b0;
    pc_jump_o      = 1'b0;
    pc_jump_addr_o = '0;
    if_id_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_hold_o   = 1'b0;
    id_ex_flush_o  = 1'b0;

    if (hold_req_i) begin
      // EX is frozen too, so a pending jump is simply taken once hold drops.
      pc_hold_o    = 1'b1;
      if_id_hold_o = 1'b1;
      id_ex_hold_o = 1'b1;
    end else begin
      advance = 1'b1;
      unique case (state_q)
        StRun: begin
          if (ex_jump_i) begin
            pc_jump_o      = 1'b1;
            pc_jump_addr_o = ex_jump_addr_i;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_d     = StFlush;
              flush_cnt_d = 2'(FLUSH_CYC - 1);
            end
          end else if (raw_haz) begin
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
            id_ex_flush_o = 1'b1;
          end else begin
            issue = id_valid_i;
          end
        end
        StFlush: begin
          // EX holds a bubble here, so ex_jump_i cannot be genuine.
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          if (flush_cnt_q <= 2'd1) begin
            state_d     = StRun;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
      endcase
    end

    if (rst) begin
      pc_hold_o      = 1'b0;
      pc_jump_o      = 1'b0;
      pc_jump_addr_o = '0;
      if_id_hold_o   = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_hold_o   = 1'b0;
      id_ex_flush_o  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam int unsigned WbLat    = 3;
  localparam int unsigned FlushCyc = 2;
`ifdef PIPE_CTRL_FWD_EN
  localparam int AluStalls  = 0;
  localparam int LoadStalls = 1;
`else
  localparam int AluStalls  = 3;
  localparam int LoadStalls = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_rs1_used_i, id_rs2_used_i, id_reg_wen_i, id_is_load_i;
  logic        ex_jump_i;
  logic [31:0] ex_jump_addr_i;
  logic        hold_req_i;
  logic        pc_hold_o, pc_jump_o, if_id_hold_o, if_id_flush_o;
  logic        id_ex_hold_o, id_ex_flush_o;
  logic [31:0] pc_jump_addr_o;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .WB_LAT    (WbLat),
    .FLUSH_CYC (FlushCyc)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid_i     (id_valid_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .id_reg_wen_i   (id_reg_wen_i),
    .id_is_load_i   (id_is_load_i),
    .ex_jump_i      (ex_jump_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .hold_req_i     (hold_req_i),
    .pc_hold_o      (pc_hold_o),
    .pc_jump_o      (pc_jump_o),
    .pc_jump_addr_o (pc_jump_addr_o),
    .if_id_hold_o   (if_id_hold_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_hold_o   (id_ex_hold_o),
    .id_ex_flush_o  (id_ex_flush_o)
  );

  // Output vector: {pc_hold, pc_jump, addr[31:0], if_id_hold, if_id_flush, id_ex_hold, id_ex_flush}
  logic [37:0] act;
  assign act = {pc_hold_o, pc_jump_o, pc_jump_addr_o, if_id_hold_o, if_id_flush_o,
                id_ex_hold_o, id_ex_flush_o};

  logic [37:0] exp_q [$];
  string       name_q [$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [37:0] mk(logic ph, logic pj, logic [31:0] a, logic ih, logic ifl,
                                     logic eh, logic efl);
    return {ph, pj, a, ih, ifl, eh, efl};
  endfunction

  function automatic logic [37:0] e_idle();
    return '0;
  endfunction
  function automatic logic [37:0] e_stall();
    return mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [37:0] e_hold();
    return mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [37:0] e_jump(logic [31:0] a);
    return mk(1'b0, 1'b1, a, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction
  function automatic logic [37:0] e_flush();
    return mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    logic [37:0] e;
    string       n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  task automatic id_set(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                        logic [4:0] rd, logic wen, logic ld);
    id_valid_i    = v;
    id_rs1_addr_i = rs1;
    id_rs1_used_i = u1;
    id_rs2_addr_i = rs2;
    id_rs2_used_i = u2;
    id_rd_addr_i  = rd;
    id_reg_wen_i  = wen;
    id_is_load_i  = ld;
  endtask

  task automatic clr();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_jump_i      = 1'b0;
    ex_jump_addr_i = 32'h0;
    hold_req_i     = 1'b0;
  endtask

  task automatic cyc(string n, logic [37:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;

    // Outputs forced low during reset even with active requests.
    ex_jump_i      = 1'b1;
    ex_jump_addr_i = 32'h55;
    id_set(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc("reset_jump", e_idle());
    hold_req_i = 1'b1;
    cyc("reset_hold", e_idle());
    rst = 1'b0;
    clr();

    // RAW: addi x1 ; add x2,x1,x1
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    cyc("raw_prod", e_idle());
    id_set(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
    for (int i = 0; i < AluStalls; i++) cyc("raw_stall", e_stall());
    cyc("raw_issue", e_idle());

    // x0 immunity: addi x0,x0,1 ; add x3,x0,x0
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("x0_prod", e_idle());
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    cyc("x0_use", e_idle());

    // Load-use: lw x4 ; add x5,x4,x0
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    cyc("ld_prod", e_idle());
    id_set(1'b1, 5'd4, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < LoadStalls; i++) cyc("ld_stall", e_stall());
    cyc("ld_issue", e_idle());

    // Jump wins over a pending hazard on x5; second jump in FLUSH ignored.
    id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    ex_jump_i      = 1'b1;
    ex_jump_addr_i = 32'h0000_0100;
    cyc("jump", e_jump(32'h0000_0100));
    ex_jump_addr_i = 32'h0000_0200;
    cyc("flush_ign_jump", e_flush());
    clr();
    cyc("post_flush", e_idle());

    // Hold does not decrement a pending count.
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
    cyc("hold_prod", e_idle());
    id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    hold_req_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc("hold", e_hold());
    hold_req_i = 1'b0;
    for (int i = 0; i < LoadStalls; i++) cyc("hold_stall", e_stall());
    cyc("hold_issue", e_idle());

    // Hold beats a concurrent jump; the jump is taken when hold drops.
    clr();
    hold_req_i     = 1'b1;
    ex_jump_i      = 1'b1;
    ex_jump_addr_i = 32'h0000_0300;
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("hold_jump", e_hold());
    hold_req_i = 1'b0;
    cyc("jump_after_hold", e_jump(32'h0000_0300));
    cyc("flush_after_hold", e_flush());
    clr();
    cyc("idle_after_hold", e_idle());

    // Reset mid-run while in FLUSH with x5 busy.
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    cyc("rst_prod", e_idle());
    clr();
    ex_jump_i      = 1'b1;
    ex_jump_addr_i = 32'h0000_0400;
    cyc("rst_jump", e_jump(32'h0000_0400));
    ex_jump_i = 1'b0;
    id_set(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("rst_mid", e_idle());
    rst = 1'b0;
    cyc("rst_after_no_stall", e_idle());
    clr();
    cyc("final_idle", e_idle());

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 3-stage core: IF (pc), if_id, ID, id_ex, EX.
- Owns a per-register scoreboard of in-flight writebacks and inserts bubbles when an ID operand is not yet available.
- Redirects the pc and flushes younger stages on an EX-resolved jump; freezes the whole pipe on an external bus hold.

Parameters:
- WB_LAT, 3: cycles from ID issue until the result is readable from the register file; range 1..7.
- FLUSH_CYC, 1: cycles if_id/id_ex flush stays asserted after an accepted jump; range 1..3.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_addr_i  in  5  ID source 1 index
- id_rs2_addr_i  in  5  ID source 2 index
- id_rs1_used_i  in  1  source 1 is read by this instruction
- id_rs2_used_i  in  1  source 2 is read by this instruction
- id_rd_addr_i  in  5  ID destination index
- id_reg_wen_i  in  1  ID instruction writes rd
- id_is_load_i  in  1  ID instruction is a load (used only with PIPE_CTRL_FWD_EN)
- ex_jump_i  in  1  EX resolved a taken jump/branch
- ex_jump_addr_i  in  32  jump target
- hold_req_i  in  1  bus/memory requests a full-pipe freeze
- pc_hold_o  out  1  pc keeps its value
- pc_jump_o  out  1  pc loads pc_jump_addr_o
- pc_jump_addr_o  out  32  redirect target
- if_id_hold_o  out  1  if_id keeps its contents
- if_id_flush_o  out  1  if_id loads a NOP (inst 32'h00000013)
- id_ex_hold_o  out  1  id_ex keeps its contents
- id_ex_flush_o  out  1  id_ex loads a bubble (reg_wen=0, rd=0)

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. While rst is high, all outputs are 0, all scoreboard counters are 0, state is RUN and flush_cnt is 0.
- State machine: RUN and FLUSH. Outputs are combinational from state and inputs, with priority hold > jump > hazard.
- hold_req_i=1, in either state:
  - pc_hold_o=if_id_hold_o=id_ex_hold_o=1; all other outputs 0.
  - Scoreboard does not decrement and nothing issues.
  - flush_cnt does not advance.
  - ex_jump_i is ignored; EX is frozen, so the jump is still present and is taken in the first cycle hold_req_i=0.
- RUN with ex_jump_i=1:
  - pc_jump_o=1, pc_jump_addr_o=ex_jump_addr_i, if_id_flush_o=id_ex_flush_o=1.
  - If FLUSH_CYC>1: go to FLUSH with flush_cnt=FLUSH_CYC-1.
- FLUSH:
  - if_id_flush_o=id_ex_flush_o=1 and pc_jump_o=0.
  - flush_cnt decrements each cycle; return to RUN when it reaches 1.
  - ex_jump_i in FLUSH is ignored, because EX holds a bubble.
- Hazard (RUN, no jump): haz = id_valid_i & ((rs1_used & rs1!=0 & cnt[rs1]!=0) | (rs2_used & rs2!=0 & cnt[rs2]!=0)).
  - On haz: pc_hold_o=if_id_hold_o=1 and id_ex_flush_o=1 (bubble).
- Issue: issue = id_valid_i & RUN & !haz & !ex_jump_i & !hold_req_i.
  - If issue & id_reg_wen_i & rd!=0, then cnt[rd] is set to WB_LAT.
- Scoreboard:
  - 32 counters of width $clog2(WB_LAT+1); cnt[0] is constant 0.
  - Each non-held cycle, every nonzero counter decrements.
  - Issue to the same rd in the same cycle wins over the decrement (WAW restart).
  - Instructions killed by a flush never issue, so no scoreboard cleanup is required.
- No combinational path from any *_hold_o/*_flush_o output back to an input.

Optional Feature:
- Macro PIPE_CTRL_FWD_EN.
- Defined:
  - EX/MEM forwarding exists, so counters are set only for loads: issue & id_is_load_i & id_reg_wen_i & rd!=0 sets cnt[rd]=1.
  - The result is exactly one bubble on load-use; ALU results never stall.
- Undefined: the full WB_LAT scoreboard above; id_is_load_i is unused.

Decomposition:
- Shared defines file: NOP encoding 32'h00000013, state encodings RUN/FLUSH, zero-register index.
- One sub-module, pipe_scoreboard: counters, issue/decrement logic, and the two lookups returning rs1_busy and rs2_busy.
- FSM and output muxing remain in pipe_ctrl.

Test Plan:
- Reset mid-run: assert rst while cnt[5]=2 and in FLUSH -> all outputs 0 immediately; after release, an ID read of x5 does not stall.
- RAW stall, WB_LAT=3, no FWD: issue addi x1 then add x2,x1,x1 -> exactly 3 cycles with pc_hold_o=if_id_hold_o=id_ex_flush_o=1, then the add issues.
- x0 immunity: issue addi x0,x0,1 then add x3,x0,x0 -> no stall.
- Jump, FLUSH_CYC=2: ex_jump_i=1, addr 32'h0000_0100 -> pc_jump_o=1 for one cycle with addr 0x100; if_id_flush_o/id_ex_flush_o high for 2 cycles; a second ex_jump_i in cycle 2 is ignored.
- Hold priority: hold_req_i=1 for 4 cycles concurrent with ex_jump_i and a pending cnt[1]=2 -> all three holds high, no jump; cnt[1] is still 2 after the hold; the jump is taken in the cycle hold drops.
- With PIPE_CTRL_FWD_EN: lw x4 then add x5,x4,x0 -> exactly 1 bubble; addi x4 then add x5,x4,x0 -> 0 bubbles.
